log_lane_scheduler: RTL and testbench

- Per-frame motion controller for the river logs.
- Owns the start coordinates of every log and advances each lane once per video frame, at that lane's own speed and direction. Lanes wrap at the screen edges.
- Drives the ObjectStartX/ObjectStartY arrays consumed by the log drawing block.
- Publishes per-lane shift flags so the frog controller can carry a frog riding a log.

---
 rtl/frog_pkg.sv | 33 +++
 rtl/lane_stepper.sv | 30 +++
 rtl/log_lane_scheduler.sv | 167 ++++++++++++++++
 tb/tb_log_lane_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/frog_pkg.sv
// Shared frog-game types and river geometry, used by the log scheduler,
// the log drawing block and the frog controller.
package frog_pkg;

  localparam int COORD_W       = 11;
  localparam int SCREEN_W      = 640;

  localparam int NUM_LANES     = 5;
  localparam int LOGS_PER_LANE = 4;
  localparam int NUM_LOGS      = NUM_LANES * LOGS_PER_LANE;
  localparam int LANE_Y_BASE   = 60;
  localparam int LANE_PITCH    = 20;
  localparam int LOG_SPACING   = 160;
  localparam int LANE_STAGGER  = 40;
  localparam logic [NUM_LANES-1:0] DIR_MASK = 5'b01010;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } sched_state_t;

  function automatic coord_t log_init_x(input int lane, input int k);
    return coord_t'((k * LOG_SPACING + lane * LANE_STAGGER) % SCREEN_W);
  endfunction

  function automatic coord_t lane_y(input int lane);
    return coord_t'(LANE_Y_BASE + lane * LANE_PITCH);
  endfunction

endpackage

// File: rtl/lane_stepper.sv
// One-pixel wrap-around step of a single X coordinate; left = 1 moves toward 0.
module lane_stepper
  import frog_pkg::*;
(
  input  coord_t x,
  input  logic   left,
  output coord_t x_next
);

  localparam coord_t X_MAX = coord_t'(SCREEN_W - 1);

  // Wrap at both screen edges
  always_comb begin
    x_next = x;
    if (left) begin
      if (x == 11'd0) begin
        x_next = X_MAX;
      end else begin
        x_next = x - 11'd1;
      end
    end else begin
      if (x == X_MAX) begin
        x_next = 11'd0;
      end else begin
        x_next = x + 11'd1;
      end
    end
  end

endmodule

// File: rtl/log_lane_scheduler.sv
// Per-frame log motion: walks the lanes one per cycle after each startOfFrame,
// stepping every log of a lane whose frame counter reaches its period.
module log_lane_scheduler
  import frog_pkg::*;
(
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         startOfFrame,
  input  logic                         restart,
  input  logic                         pause,
  input  logic [NUM_LANES-1:0][3:0]    lane_period,
  output coord_t [NUM_LOGS-1:0]        ObjectStartX,
  output coord_t [NUM_LOGS-1:0]        ObjectStartY,
  output logic [NUM_LANES-1:0]         lane_move,
  output logic [NUM_LANES-1:0]         lane_dir,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam int IDX_W = $clog2(NUM_LANES);
  localparam logic [IDX_W-1:0] LAST_LANE = IDX_W'(NUM_LANES - 1);

  sched_state_t                state;
  sched_state_t                next_state;
  logic [IDX_W-1:0]            lane_idx;
  logic [NUM_LANES-1:0][3:0]   period_sh;
  logic [NUM_LANES-1:0][3:0]   cnt;
  logic                        pause_sh;
  logic                        clear;
  logic                        busy_d;
  logic                        done_d;

  logic [3:0]                  cur_p;
  logic [3:0]                  cur_cnt;
  logic [4:0]                  cnt_inc;
  logic [3:0]                  cnt_new;
  logic                        do_step;
  int                          lane_base;
  coord_t [LOGS_PER_LANE-1:0]  cur_x;
  coord_t [LOGS_PER_LANE-1:0]  step_x;

  assign clear    = RESET | restart;
  assign lane_dir = DIR_MASK;

  // State register
  always_ff @(posedge CLK) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (startOfFrame) begin
          next_state = UPDATE;
        end else begin
          next_state = IDLE;
        end
      end
      UPDATE: begin
        if (lane_idx == LAST_LANE) begin
          next_state = DONE;
        end else begin
          next_state = UPDATE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status flags decoded from the upcoming state so they register in step with it
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    case (next_state)
      UPDATE:  busy_d = 1'b1;
      DONE:    done_d = 1'b1;
      default: begin
        busy_d = 1'b0;
        done_d = 1'b0;
      end
    endcase
  end

  // Counter decision for the lane currently selected by the walk
  always_comb begin
    cur_p     = period_sh[lane_idx];
    cur_cnt   = cnt[lane_idx];
    cnt_inc   = {1'b0, cur_cnt} + 5'd1;
    cnt_new   = cur_cnt;
    do_step   = 1'b0;
    lane_base = int'(lane_idx) * LOGS_PER_LANE;
    if (pause_sh) begin
      cnt_new = cur_cnt;
      do_step = 1'b0;
    end else if (cur_p == 4'd0) begin
      cnt_new = 4'd0;
      do_step = 1'b0;
    end else if (cnt_inc >= {1'b0, cur_p}) begin
      cnt_new = 4'd0;
      do_step = 1'b1;
    end else begin
      cnt_new = cnt_inc[3:0];
      do_step = 1'b0;
    end
    for (int k = 0; k < LOGS_PER_LANE; k++) begin
      cur_x[k] = ObjectStartX[lane_base + k];
    end
  end

  for (genvar g = 0; g < LOGS_PER_LANE; g++) begin : g_step
    lane_stepper u_step (
      .x      (cur_x[g]),
      .left   (DIR_MASK[lane_idx]),
      .x_next (step_x[g])
    );
  end

  // Walk datapath: shadows, counters, coordinates and pulses
  always_ff @(posedge CLK) begin
    if (clear) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        for (int k = 0; k < LOGS_PER_LANE; k++) begin
          ObjectStartX[l*LOGS_PER_LANE + k] <= log_init_x(l, k);
          ObjectStartY[l*LOGS_PER_LANE + k] <= lane_y(l);
        end
      end
      cnt        <= '0;
      period_sh  <= '0;
      pause_sh   <= 1'b0;
      lane_idx   <= '0;
      lane_move  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      busy       <= busy_d;
      frame_done <= done_d;
      overrun    <= startOfFrame && (state != IDLE);
      if (state == IDLE && startOfFrame) begin
        lane_idx  <= '0;
        period_sh <= lane_period;
        pause_sh  <= pause;
        lane_move <= '0;
      end else if (state == UPDATE) begin
        cnt[lane_idx]       <= cnt_new;
        lane_move[lane_idx] <= do_step;
        if (do_step) begin
          for (int k = 0; k < LOGS_PER_LANE; k++) begin
            ObjectStartX[lane_base + k] <= step_x[k];
          end
        end
        if (lane_idx != LAST_LANE) begin
          lane_idx <= lane_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_log_lane_scheduler.sv
// Randomized bench for log_lane_scheduler against a per-frame arithmetic model.
module tb_log_lane_scheduler;
  import frog_pkg::*;

  localparam int L  = 5;
  localparam int K  = 4;
  localparam int W  = 640;
  localparam logic [4:0] DIRS = 5'b01010;

  logic                  CLK = 1'b0;
  logic                  RESET, startOfFrame, restart, pause;
  logic [L-1:0][3:0]     lane_period;
  coord_t [L*K-1:0]      ObjectStartX, ObjectStartY;
  logic [L-1:0]          lane_move, lane_dir;
  logic                  busy, frame_done, overrun;

  always #5 CLK = ~CLK;

  log_lane_scheduler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .startOfFrame (startOfFrame),
    .restart      (restart),
    .pause        (pause),
    .lane_period  (lane_period),
    .ObjectStartX (ObjectStartX),
    .ObjectStartY (ObjectStartY),
    .lane_move    (lane_move),
    .lane_dir     (lane_dir),
    .busy         (busy),
    .frame_done   (frame_done),
    .overrun      (overrun)
  );

  int n_vec = 0;
  int n_err = 0;

  int         mx   [L][K];
  int         mcnt [L];
  logic [4:0] mmove;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_init();
    for (int l = 0; l < L; l++) begin
      mcnt[l] = 0;
      for (int k = 0; k < K; k++) mx[l][k] = (k * 160 + l * 40) % W;
    end
    mmove = 5'b0;
  endtask

  task automatic model_frame(input bit pz, input logic [L-1:0][3:0] per);
    for (int l = 0; l < L; l++) begin
      int p;
      p = int'(per[l]);
      mmove[l] = 1'b0;
      if (!pz) begin
        if (p == 0) begin
          mcnt[l] = 0;
        end else begin
          mcnt[l] = mcnt[l] + 1;
          if (mcnt[l] >= p) begin
            mcnt[l]  = 0;
            mmove[l] = 1'b1;
            for (int k = 0; k < K; k++)
              mx[l][k] = DIRS[l] ? (mx[l][k] + W - 1) % W : (mx[l][k] + 1) % W;
          end
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < L*K; i++) begin
      check_val($sformatf("%s_x%0d", tag, i), 32'(ObjectStartX[i]), 32'(mx[i/K][i%K]));
      check_val($sformatf("%s_y%0d", tag, i), 32'(ObjectStartY[i]), 32'(60 + (i/K) * 20));
    end
    check_val({tag, "_move"}, 32'(lane_move), 32'(mmove));
    check_val({tag, "_dir"},  32'(lane_dir),  32'(DIRS));
  endtask

  // One frame; dup_at >= 0 re-pulses startOfFrame during the walk
  task automatic run_frame(input string tag, input bit pz, input int dup_at);
    logic [L-1:0][3:0] per;
    @(negedge CLK);
    startOfFrame = 1'b1;
    pause        = pz;
    per          = lane_period;
    @(negedge CLK);
    startOfFrame = 1'b0;
    pause        = 1'($urandom);
    lane_period  = 20'($urandom);
    for (int j = 0; j < L; j++) begin
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_fd_early"}, 32'(frame_done), 32'd0);
      check_val({tag, "_ovr"}, 32'(overrun), 32'((dup_at >= 0) && (j == dup_at + 1)));
      startOfFrame = (j == dup_at);
      @(negedge CLK);
    end
    startOfFrame = 1'b0;
    check_val({tag, "_fd"}, 32'(frame_done), 32'd1);
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    check_val({tag, "_ovr_end"}, 32'(overrun), 32'(dup_at == L - 1));
    model_frame(pz, per);
    compare_all(tag);
    lane_period = per;
    pause       = 1'b0;
    @(negedge CLK);
    check_val({tag, "_fd_pulse"}, 32'(frame_done), 32'd0);
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_restart();
    @(negedge CLK);
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    model_init();
  endtask

  initial begin
    RESET        = 1'b1;
    startOfFrame = 1'b0;
    restart      = 1'b0;
    pause        = 1'b0;
    lane_period  = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    model_init();
    @(negedge CLK);
    check_val("rst_x00", 32'(ObjectStartX[0]), 32'd0);
    check_val("rst_x01", 32'(ObjectStartX[1]), 32'd160);
    check_val("rst_x10", 32'(ObjectStartX[4]), 32'd40);
    check_val("rst_x43", 32'(ObjectStartX[19]), 32'd0);
    check_val("rst_y2",  32'(ObjectStartY[8]), 32'd100);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fd",   32'(frame_done), 32'd0);
    check_val("rst_ovr",  32'(overrun), 32'd0);
    compare_all("rst");

    for (int l = 0; l < L; l++) lane_period[l] = 4'd1;
    run_frame("p1", 1'b0, -1);
    check_val("p1_x00", 32'(ObjectStartX[0]), 32'd1);
    check_val("p1_x10", 32'(ObjectStartX[4]), 32'd39);
    check_val("p1_move", 32'(lane_move), 32'd31);

    do_restart();
    lane_period    = '0;
    lane_period[0] = 4'd3;
    for (int f = 1; f <= 6; f++) begin
      run_frame("p3", 1'b0, -1);
      check_val($sformatf("p3_move_f%0d", f), 32'(lane_move[0]), 32'(f % 3 == 0));
    end
    check_val("p3_x00", 32'(ObjectStartX[0]), 32'd2);

    do_restart();
    for (int l = 0; l < L; l++) lane_period[l] = 4'd1;
    for (int f = 1; f <= 160; f++) begin
      run_frame("wrap", 1'b0, -1);
      if (f == 40)  check_val("wrap_left_0",    32'(ObjectStartX[4]), 32'd0);
      if (f == 41)  check_val("wrap_left_639",  32'(ObjectStartX[4]), 32'd639);
      if (f == 159) check_val("wrap_right_639", 32'(ObjectStartX[3]), 32'd639);
      if (f == 160) check_val("wrap_right_0",   32'(ObjectStartX[3]), 32'd0);
    end

    run_frame("ovr", 1'b0, 1);

    for (int f = 0; f < 4; f++) run_frame("pause", 1'b1, -1);

    repeat (120) begin
      int dup;
      for (int l = 0; l < L; l++)
        lane_period[l] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      dup = $urandom_range(0, 7);
      if (dup > L - 1) dup = -1;
      run_frame("rnd", ($urandom_range(0, 3) == 0), dup);
    end

    @(negedge CLK);
    startOfFrame = 1'b1;
    @(negedge CLK);
    startOfFrame = 1'b0;
    check_val("abort_busy_pre", 32'(busy), 32'd1);
    @(negedge CLK);
    restart = 1'b1;
    @(negedge CLK);
    restart = 1'b0;
    model_init();
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_fd",   32'(frame_done), 32'd0);
    compare_all("abort");
    for (int c = 0; c < 6; c++) begin
      check_val("abort_no_fd", 32'(frame_done), 32'd0);
      @(negedge CLK);
    end
    run_frame("after_abort", 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
